// File: rtl/rv_csr_pkg.sv
// rtl/rv_csr_pkg.sv - shared CSR addresses, trap causes, mstatus fields and trap FSM states
package rv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_BREAK   = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] CAUSE_NONE    = 32'd63;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        T_EPC   = 3'd1,
        T_CAUSE = 3'd2,
        T_TVAL  = 3'd3,
        T_STAT  = 3'd4,
        T_REDIR = 3'd5,
        R_STAT  = 3'd6,
        R_REDIR = 3'd7
    } trap_state_e;

endpackage

// File: rtl/trap_vec.sv
// rtl/trap_vec.sv - trap handler address from mtvec, cause and interrupt flag
module trap_vec #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mtvec,
    input  logic [31:0]     cause,
    input  logic            is_irq,
    output logic [XLEN-1:0] target
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;
    logic [32:0]     offset_full;

    assign base        = {mtvec[XLEN-1:2], 2'b00};
    assign offset_full = {cause[30:0], 2'b00};
    assign offset      = XLEN'(offset_full);

    // Vectored mode only applies to interrupts; exceptions always land on the base.
    always_comb begin
        target = base;
        if (is_irq && (mtvec[1:0] == 2'b01)) begin
            target = base + offset;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/mret sequencer driving the CSR write port and fetch redirect
module trap_ctrl
    import rv_csr_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] IRQ_CAUSE = 32'h8000000B
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_inst,
    input  logic            i_excp_en,
    input  logic [31:0]     i_excp,
    input  logic            i_return,
    input  logic            i_irq,
    input  logic [XLEN-1:0] i_mstatus,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_pc_next,
    output logic            o_csr_we,
    output logic [11:0]     o_csr_waddr,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic            o_busy
);

    trap_state_e     state_q;
    trap_state_e     state_d;

    logic [XLEN-1:0] pc_q;
    logic [31:0]     cause_q;
    logic [31:0]     inst_q;
    logic            irq_q;

    logic            latch_en;
    logic            latch_irq;
    logic            take_irq;
    logic            take_exc;
    logic            take_ret;
    logic [XLEN-1:0] trap_status;
    logic [XLEN-1:0] ret_status;
    logic [XLEN-1:0] vec_target;

    assign take_irq = i_valid && i_irq && i_mstatus[MSTATUS_MIE];
    assign take_exc = i_valid && i_excp_en;
    assign take_ret = i_valid && i_return;

    // mstatus images for trap entry and mret; fields not named here pass through untouched.
    always_comb begin
        trap_status                              = i_mstatus;
        trap_status[MSTATUS_MPIE]                = i_mstatus[MSTATUS_MIE];
        trap_status[MSTATUS_MIE]                 = 1'b0;
        trap_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        ret_status                               = i_mstatus;
        ret_status[MSTATUS_MIE]                  = i_mstatus[MSTATUS_MPIE];
        ret_status[MSTATUS_MPIE]                 = 1'b1;
        ret_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    end

    trap_vec #(
        .XLEN(XLEN)
    ) u_trap_vec (
        .mtvec  (i_mtvec),
        .cause  (cause_q),
        .is_irq (irq_q),
        .target (vec_target)
    );

    // State register and trap context capture taken on the detection edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            inst_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                pc_q    <= i_pc;
                cause_q <= latch_irq ? IRQ_CAUSE : i_excp;
                inst_q  <= i_inst;
                irq_q   <= latch_irq;
            end
        end
    end

    // Next state and outputs; only the IDLE detection stall looks at the decode inputs.
    always_comb begin
        state_d     = state_q;
        latch_en    = 1'b0;
        latch_irq   = 1'b0;
        o_stall     = 1'b0;
        o_flush     = 1'b0;
        o_redirect  = 1'b0;
        o_pc_next   = '0;
        o_csr_we    = 1'b0;
        o_csr_waddr = '0;
        o_csr_wdata = '0;
        o_busy      = 1'b1;

        case (state_q)
            IDLE: begin
                o_busy = 1'b0;
                if (!rst) begin
                    if (take_irq) begin
                        o_stall   = 1'b1;
                        latch_en  = 1'b1;
                        latch_irq = 1'b1;
                        state_d   = T_EPC;
                    end else if (take_exc) begin
                        o_stall  = 1'b1;
                        latch_en = 1'b1;
                        state_d  = T_EPC;
                    end else if (take_ret) begin
                        o_stall = 1'b1;
                        state_d = R_STAT;
                    end
                end
            end
            T_EPC: begin
                o_stall     = 1'b1;
                o_csr_we    = 1'b1;
                o_csr_waddr = CSR_MEPC;
                o_csr_wdata = {pc_q[XLEN-1:2], 2'b00};
                state_d     = T_CAUSE;
            end
            T_CAUSE: begin
                o_stall     = 1'b1;
                o_csr_we    = 1'b1;
                o_csr_waddr = CSR_MCAUSE;
                o_csr_wdata = XLEN'(cause_q);
                state_d     = T_TVAL;
            end
            T_TVAL: begin
                o_stall     = 1'b1;
                o_csr_we    = 1'b1;
                o_csr_waddr = CSR_MTVAL;
                o_csr_wdata = (cause_q == CAUSE_ILLEGAL) ? XLEN'(inst_q) : '0;
                state_d     = T_STAT;
            end
            T_STAT: begin
                o_stall     = 1'b1;
                o_csr_we    = 1'b1;
                o_csr_waddr = CSR_MSTATUS;
                o_csr_wdata = trap_status;
                state_d     = T_REDIR;
            end
            T_REDIR: begin
                o_flush    = 1'b1;
                o_redirect = 1'b1;
                o_pc_next  = vec_target;
                state_d    = IDLE;
            end
            R_STAT: begin
                o_stall     = 1'b1;
                o_csr_we    = 1'b1;
                o_csr_waddr = CSR_MSTATUS;
                o_csr_wdata = ret_status;
                state_d     = R_REDIR;
            end
            R_REDIR: begin
                o_flush    = 1'b1;
                o_redirect = 1'b1;
                o_pc_next  = i_mepc;
                state_d    = IDLE;
            end
            default: begin
                o_busy  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - randomized self-checking bench for trap_ctrl with a sequence-level reference model
module tb_trap_ctrl;

    typedef struct {
        bit          stall;
        bit          flush;
        bit          redir;
        logic [31:0] pc;
        bit          we;
        logic [11:0] addr;
        logic [31:0] data;
        bit          busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_pc;
    logic [31:0] i_inst;
    logic        i_excp_en;
    logic [31:0] i_excp;
    logic        i_return;
    logic        i_irq;
    logic [31:0] b_mstatus;
    logic [31:0] b_mtvec;
    logic [31:0] b_mepc;
    logic        o_stall;
    logic        o_flush;
    logic        o_redirect;
    logic [31:0] o_pc_next;
    logic        o_csr_we;
    logic [11:0] o_csr_waddr;
    logic [31:0] o_csr_wdata;
    logic        o_busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    exp_t        mq[$];
    logic [11:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int          n_redir;
    int          redir_cyc;
    logic [31:0] last_redir;
    bit          pend_we;
    logic [11:0] pend_addr;
    logic [31:0] pend_data;
    int          t0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_pc       (i_pc),
        .i_inst     (i_inst),
        .i_excp_en  (i_excp_en),
        .i_excp     (i_excp),
        .i_return   (i_return),
        .i_irq      (i_irq),
        .i_mstatus  (b_mstatus),
        .i_mtvec    (b_mtvec),
        .i_mepc     (b_mepc),
        .o_stall    (o_stall),
        .o_flush    (o_flush),
        .o_redirect (o_redirect),
        .o_pc_next  (o_pc_next),
        .o_csr_we   (o_csr_we),
        .o_csr_waddr(o_csr_waddr),
        .o_csr_wdata(o_csr_wdata),
        .o_busy     (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t csr_step(input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        e = '{default: '0};
        e.stall = 1; e.busy = 1; e.we = 1; e.addr = a; e.data = d;
        return e;
    endfunction

    function automatic exp_t redir_step(input logic [31:0] target);
        exp_t e;
        e = '{default: '0};
        e.busy = 1; e.flush = 1; e.redir = 1; e.pc = target;
        return e;
    endfunction

    // Idle-cycle prediction: decide from the architectural rules whether a trap
    // or mret starts, and if so queue the whole expected sequence.
    task automatic predict(output exp_t e);
        bit          irq, exc, ret;
        logic [31:0] cause, st, base, target;
        e = '{default: '0};
        irq = i_valid && i_irq && b_mstatus[3];
        exc = i_valid && i_excp_en && !irq;
        ret = i_valid && i_return && !irq && !exc;
        if (irq || exc) begin
            e.stall = 1;
            cause = irq ? 32'h8000000B : i_excp;
            st = b_mstatus;
            st[7] = b_mstatus[3];
            st[3] = 1'b0;
            st[12:11] = 2'b11;
            base = b_mtvec & ~32'h3;
            target = (irq && b_mtvec[1:0] == 2'b01) ? base + 4 * (cause & 32'h7FFFFFFF) : base;
            mq.push_back(csr_step(12'h341, i_pc & ~32'h3));
            mq.push_back(csr_step(12'h342, cause));
            mq.push_back(csr_step(12'h343, (cause == 2) ? i_inst : 32'h0));
            mq.push_back(csr_step(12'h300, st));
            mq.push_back(redir_step(target));
        end else if (ret) begin
            e.stall = 1;
            st = b_mstatus;
            st[3] = b_mstatus[7];
            st[7] = 1'b1;
            st[12:11] = 2'b11;
            mq.push_back(csr_step(12'h300, st));
            mq.push_back(redir_step(b_mepc));
        end
    endtask

    // One clock: compare at negedge, then apply the model's CSR write just after posedge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        e = '{default: '0};
        if (mq.size() > 0) e = mq.pop_front();
        else if (!rst) predict(e);
        if (rst) mq.delete();
        check("stall",    32'(o_stall),     32'(e.stall));
        check("flush",    32'(o_flush),     32'(e.flush));
        check("redirect", 32'(o_redirect),  32'(e.redir));
        check("pc_next",  o_pc_next,        e.pc);
        check("csr_we",   32'(o_csr_we),    32'(e.we));
        check("csr_addr", 32'(o_csr_waddr), 32'(e.addr));
        check("csr_data", o_csr_wdata,      e.data);
        check("busy",     32'(o_busy),      32'(e.busy));
        if (o_csr_we) begin
            wa.push_back(o_csr_waddr);
            wd.push_back(o_csr_wdata);
            wc.push_back(cyc);
        end
        if (o_redirect) begin
            n_redir++;
            last_redir = o_pc_next;
            redir_cyc = cyc;
        end
        pend_we = e.we; pend_addr = e.addr; pend_data = e.data;
        cyc++;
        @(posedge clk);
        #1;
        if (pend_we) begin
            if (pend_addr == 12'h300) b_mstatus = pend_data;
            if (pend_addr == 12'h341) b_mepc = pend_data;
        end
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_excp_en = 0; i_excp = 32'd63; i_return = 0; i_irq = 0;
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete();
        n_redir = 0; redir_cyc = -1; last_redir = 32'hDEADBEEF;
    endtask

    function automatic logic [31:0] wd_at(input int i);
        return (i < wd.size()) ? wd[i] : 32'hDEADBEEF;
    endfunction

    function automatic logic [11:0] wa_at(input int i);
        return (i < wa.size()) ? wa[i] : 12'hFFF;
    endfunction

    function automatic int wc_at(input int i);
        return (i < wc.size()) ? wc[i] : -100;
    endfunction

    task automatic detect_then_idle(input int n);
        t0 = cyc;
        cycle();
        idle_inputs();
        repeat (n) cycle();
    endtask

    initial begin
        logic [31:0] r;
        rst = 1; idle_inputs();
        i_pc = 0; i_inst = 0; b_mstatus = 0; b_mtvec = 0; b_mepc = 0;
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst = 0;
        cycle();

        // ECALL
        clear_log();
        b_mtvec = 32'h200; b_mstatus = 32'h8;
        i_valid = 1; i_pc = 32'h100; i_inst = 32'h00000073; i_excp_en = 1; i_excp = 32'd11;
        detect_then_idle(6);
        check("ecall_mepc_addr", 32'(wa_at(0)), 32'h341);
        check("ecall_mepc",      wd_at(0), 32'h100);
        check("ecall_mcause",    wd_at(1), 32'd11);
        check("ecall_mtval",     wd_at(2), 32'h0);
        check("ecall_mstatus",   wd_at(3), 32'h1880);
        check("ecall_first_we",  32'(wc_at(0) - t0), 32'd1);
        check("ecall_target",    last_redir, 32'h200);
        check("ecall_redir_cyc", 32'(redir_cyc - t0), 32'd5);

        // Illegal instruction
        clear_log();
        i_valid = 1; i_pc = 32'h40; i_inst = 32'hFFFFFFFF; i_excp_en = 1; i_excp = 32'd2;
        detect_then_idle(6);
        check("ill_mepc",   wd_at(0), 32'h40);
        check("ill_mcause", wd_at(1), 32'd2);
        check("ill_mtval",  wd_at(2), 32'hFFFFFFFF);

        // Vectored interrupt beating a simultaneous ECALL
        clear_log();
        b_mstatus = 32'h8; b_mtvec = 32'h301;
        i_valid = 1; i_pc = 32'h80; i_inst = 32'h00000073; i_excp_en = 1; i_excp = 32'd11; i_irq = 1;
        detect_then_idle(6);
        check("irq_mcause", wd_at(1), 32'h8000000B);
        check("irq_target", last_redir, 32'h32C);

        // Interrupt masked by MIE=0
        clear_log();
        b_mstatus = 32'h0;
        i_valid = 1; i_pc = 32'h90; i_irq = 1;
        detect_then_idle(4);
        check("masked_writes", 32'(wa.size()), 32'd0);
        check("masked_redir",  32'(n_redir), 32'd0);

        // MRET
        clear_log();
        b_mstatus = 32'h1880; b_mepc = 32'h104;
        i_valid = 1; i_return = 1;
        detect_then_idle(4);
        check("mret_addr",      32'(wa_at(0)), 32'h300);
        check("mret_mstatus",   wd_at(0), 32'h1888);
        check("mret_we_cyc",    32'(wc_at(0) - t0), 32'd1);
        check("mret_target",    last_redir, 32'h104);
        check("mret_redir_cyc", 32'(redir_cyc - t0), 32'd2);

        // Reset at T+2 of a trap
        clear_log();
        b_mstatus = 32'h8; b_mtvec = 32'h200;
        i_valid = 1; i_pc = 32'h300; i_inst = 32'h00000073; i_excp_en = 1; i_excp = 32'd11;
        cycle();
        idle_inputs();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        repeat (6) cycle();
        check("rst_redir",  32'(n_redir), 32'd0);
        check("rst_writes", 32'(wa.size()), 32'd2);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if (mq.size() == 0 && $urandom_range(0, 7) == 0) begin
                r = $urandom();
                b_mtvec = {r[31:2], 1'b0, r[0]};
                b_mstatus = $urandom();
                b_mepc = $urandom();
            end
            rst = ($urandom_range(0, 199) == 0);
            i_valid = ($urandom_range(0, 3) != 0);
            i_pc = $urandom();
            i_inst = $urandom();
            i_excp_en = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 2))
                0: i_excp = 32'd2;
                1: i_excp = 32'd3;
                default: i_excp = 32'd11;
            endcase
            if (!i_excp_en) i_excp = 32'd63;
            i_return = ($urandom_range(0, 5) == 0);
            i_irq = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
